mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 64-bit graph-memory read port between the pipeline stages that fetch vertex and edge properties (ReadSrcProperty, ReadEdge, ReadDstProperty and similar). It accepts one request at a time from up to `NUM_REQ` stages and drives it onto the memory port. It waits for the memory's completion, then returns the data and a completion pulse to the stage that issued the request. It sits between the stage `complete`/`src_data` inputs and the memory model or controller.

## Interface
- `NUM_REQ`, 4: number of requesting stages (2..8).
- `ADDR_W`, 32: memory address width.
- `DATA_W`, 64: memory data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: stage i requests a read.
- `req_addr`  in  NUM_REQ*ADDR_W  address of stage i, at `[i*ADDR_W +: ADDR_W]`.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: the request of stage i was accepted.
- `rsp_complete`  out  NUM_REQ  one-hot, one-cycle pulse: the read for stage i is done.
- `rsp_data`  out  DATA_W  read data; valid with `rsp_complete`, then held.
- `mem_req`  out  1  request valid to memory.
- `mem_addr`  out  ADDR_W  request address.
- `mem_ready`  in  1  memory accepts the request when `mem_req && mem_ready`.
- `mem_complete`  in  1  one-cycle pulse: read data is present on `mem_data`.
- `mem_data`  in  DATA_W  read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- At most one memory request is outstanding at any time.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is set, the arbiter picks a winner.
  - It latches `owner` and `req_addr[owner]`.
  - Next state is ISSUE.
  - If no `req_valid` bit is set, it stays in IDLE.
- **ISSUE:**
  - `mem_req`=1 and `mem_addr`=latched address.
  - `req_ready[owner]` pulses in the first ISSUE cycle only.
  - It stays in ISSUE until `mem_ready`=1, then moves to WAIT.
- **WAIT:**
  - `mem_req`=0.
  - On `mem_complete`=1, `mem_data` is registered into `rsp_data`, and the next state is RESP.
- **RESP:**
  - `rsp_complete[owner]`=1 for exactly this one cycle.
  - Next state is IDLE.
- A requester holds `req_valid` and its address stable until it sees its `req_ready`. It must deassert `req_valid` (or present a new request) the cycle after `req_ready`.
- **Arbitration** is round-robin. The pointer `rr_ptr` resets to 0. The search starts at `rr_ptr` and wraps modulo `NUM_REQ`. After a grant to stage i, `rr_ptr` becomes (i+1) mod `NUM_REQ`; wrap from `NUM_REQ-1` gives 0.
- `mem_complete` outside WAIT is ignored. This includes a spurious pulse and a pulse that arrives after a reset mid-transaction.
- A `req_valid` bit that changes while the block is not in IDLE has no effect until the next IDLE cycle.
- **Reset mid-operation:** the FSM returns to IDLE. The in-flight request is abandoned and no `rsp_complete` is issued for it.

## Timing
- **Reset values:**
  - `req_ready`=0, `rsp_complete`=0, `rsp_data`=0
  - `mem_req`=0, `mem_addr`=0, `busy`=0
  - `rr_ptr`=0, `owner`=0
- All outputs are registered or decoded from state and registers only. There are no combinational input-to-output paths.
- Request sampled in IDLE at cycle T:
  - `mem_req` and `req_ready[owner]` are high at T+1.
  - With `mem_ready` held high, WAIT is entered at T+2.
- `mem_complete` at cycle C gives `rsp_complete` and `rsp_data` at C+1. IDLE is re-entered at C+2.
- Minimum spacing between grants is 4 cycles (zero-wait memory with `mem_complete` at T+2).

## Configuration
- `MEM_ARB_FIXED_PRI_EN`:
  - **Defined:** fixed priority. The lowest-index valid requester always wins, and `rr_ptr` is neither updated nor used.
  - **Undefined (default):** round-robin as described in Operation.

## Test plan
- **Single request:** reset, then `req_valid`=4'b0100 with address 0x100 and `mem_ready`=1; `mem_complete` arrives 3 cycles after `mem_req` with data 0xDEADBEEF_00000001. Expected: `req_ready`=4'b0100 for one cycle; `mem_addr`=0x100; `rsp_complete`=4'b0100 one cycle after `mem_complete`; `rsp_data` equals the returned data and is held afterwards.
- **Round-robin:** all four stages request continuously. Expected grant order 0,1,2,3,0. With `MEM_ARB_FIXED_PRI_EN` defined, the order is 0,0,0 (stage 0 re-requests each time).
- **Back-pressure:** `mem_ready`=0 for 5 cycles. Expected: `mem_req` and `mem_addr` are held stable; `req_ready` pulses only once; WAIT is entered the cycle after `mem_ready` rises.
- **Spurious completion:** a `mem_complete` pulse while in IDLE and another while in ISSUE. Expected: no `rsp_complete`, and `rsp_data` is unchanged.
- **Reset mid-transaction:** assert `reset` while in WAIT, then pulse `mem_complete`. Expected: all outputs go to their reset values asynchronously, no `rsp_complete` is issued, and the next request is granted to stage 0 first.
- **Pointer wrap:** grant stage 3, then stages 0 and 3 both request. Expected: stage 0 wins, then stage 3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates up to NUM_REQ pipeline stages onto the single graph-memory read port.
// Optional macro MEM_ARB_FIXED_PRI_EN selects fixed (lowest index wins) priority instead of round-robin.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_complete,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ready,
    input  logic                      mem_complete,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      busy,
    output logic [1:0]                fsm_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Handshakes: a stage holds req_valid and its address until it sees its
    // one-cycle req_ready; mem_req is held until mem_ready; mem_complete is a pulse.

    logic [1:0]         state;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand_idx;
    logic               found;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  win_addr;
    logic [NUM_REQ-1:0] ready_q;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    int                 cand;

`ifndef MEM_ARB_FIXED_PRI_EN
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_FIXED_PRI_EN
            cand = k;
`else
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
            cand_idx = PTR_W'(cand);
            if (!found && req_valid[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
        win_addr = addr_arr[winner];
    end

`ifndef MEM_ARB_FIXED_PRI_EN
    assign next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
`endif

    always_comb begin
        grant_oh         = '0;
        grant_oh[winner] = 1'b1;
        owner_oh         = '0;
        owner_oh[owner]  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            addr_q   <= '0;
            ready_q  <= '0;
            rsp_data <= '0;
`ifndef MEM_ARB_FIXED_PRI_EN
            rr_ptr   <= '0;
`endif
        end else begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= winner;
                        addr_q  <= win_addr;
                        ready_q <= grant_oh;
                        state   <= ISSUE;
`ifndef MEM_ARB_FIXED_PRI_EN
                        rr_ptr  <= next_ptr;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready) state <= WAIT;
                end
                WAIT: begin
                    if (mem_complete) begin
                        rsp_data <= mem_data;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every output comes from state or registers; no input reaches an output combinationally.
    assign req_ready    = ready_q;
    assign rsp_complete = (state == RESP) ? owner_oh : '0;
    assign mem_req      = (state == ISSUE);
    assign mem_addr     = addr_q;
    assign busy         = (state != IDLE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand sequences for
// asynchronous reset, round-robin order and pointer wrap.
module tb_mem_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*AW-1:0] req_addr = {32'h0000_3000, 32'h0000_0100, 32'h0000_2000, 32'h0000_1000};
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  rsp_complete;
    logic [DW-1:0]  rsp_data;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic           mem_ready = 1'b0;
    logic           mem_complete = 1'b0;
    logic [DW-1:0]  mem_data = '0;
    logic           busy;
    logic [1:0]     fsm_state;

    mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_complete (rsp_complete),
        .rsp_data     (rsp_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_complete (mem_complete),
        .mem_data     (mem_data),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rv;
        logic        mr;
        logic        mc;
        logic [63:0] md;
        logic [3:0]  e_rdy;
        logic [3:0]  e_cmp;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [1:0]  e_st;
        logic [63:0] e_data;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] exp_q[$];
    int         n_vec = 0;
    int         n_miss = 0;

    localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] D2 = 64'h01234567_89ABCDEF;

    task automatic add(input logic [3:0] rv, input logic mr, input logic mc, input logic [63:0] md,
                       input logic [3:0] e_rdy, input logic [3:0] e_cmp, input logic e_mreq,
                       input logic [31:0] e_addr, input logic e_busy, input logic [1:0] e_st,
                       input logic [63:0] e_data);
        vec_t v;
        v.rv = rv; v.mr = mr; v.mc = mc; v.md = md;
        v.e_rdy = e_rdy; v.e_cmp = e_cmp; v.e_mreq = e_mreq; v.e_addr = e_addr;
        v.e_busy = e_busy; v.e_st = e_st; v.e_data = e_data;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [107:0] snap();
        return {req_ready, rsp_complete, mem_req, mem_addr, busy, fsm_state, rsp_data};
    endfunction

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Holds rv asserted and serves n grants with a zero-wait memory, checking each against exp_q.
    task automatic do_grants(input logic [3:0] rv, input int n);
        bit         got;
        logic [3:0] oh;
        logic [1:0] want;
        logic [63:0] dat;
        req_valid    = rv;
        mem_ready    = 1'b1;
        mem_complete = 1'b0;
        for (int g = 0; g < n; g++) begin
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                tick();
                if (req_ready != 4'b0000) got = 1'b1;
            end
            if (!got) begin
                n_vec++;
                n_miss++;
                $display("FAIL grant_timeout: got no req_ready want one within 12 cycles");
                req_valid = '0;
                return;
            end
            oh   = req_ready;
            want = exp_q.pop_front();
            check($sformatf("grant%0d", g), 108'(oh), 108'(4'b0001 << want));
            tick();
            check($sformatf("enter_wait%0d", g), 108'(fsm_state), 108'(2'd2));
            dat          = 64'hA0 + 64'(want);
            mem_complete = 1'b1;
            mem_data     = dat;
            tick();
            mem_complete = 1'b0;
            check($sformatf("resp%0d", g), 108'({rsp_complete, rsp_data}),
                  108'({4'b0001 << want, dat}));
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        // Single request from stage 2, completion three cycles after mem_req.
        add(4'b0100, 1, 0, 64'h0, 4'b0100, 4'b0000, 1, 32'h100, 1, 2'd1, 64'h0);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h100, 1, 2'd2, 64'h0);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h100, 1, 2'd2, 64'h0);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h100, 1, 2'd2, 64'h0);
        add(4'b0000, 1, 1, D1,    4'b0000, 4'b0100, 0, 32'h100, 1, 2'd3, D1);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h100, 0, 2'd0, D1);
        // Spurious completion in IDLE, then stage 1 (pointer at 3 wraps to 0, 1).
        add(4'b0000, 1, 1, 64'h1111, 4'b0000, 4'b0000, 0, 32'h100, 0, 2'd0, D1);
        add(4'b0010, 0, 0, 64'h0, 4'b0010, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        // Back-pressure: five ISSUE cycles, one with a spurious completion.
        add(4'b0000, 0, 1, 64'h2222, 4'b0000, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        add(4'b0000, 0, 0, 64'h0, 4'b0000, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        add(4'b0000, 0, 0, 64'h0, 4'b0000, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        add(4'b0000, 0, 0, 64'h0, 4'b0000, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        add(4'b0000, 0, 0, 64'h0, 4'b0000, 4'b0000, 1, 32'h2000, 1, 2'd1, D1);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h2000, 1, 2'd2, D1);
        add(4'b1000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h2000, 1, 2'd2, D1);
        add(4'b1000, 1, 1, D2,    4'b0000, 4'b0010, 0, 32'h2000, 1, 2'd3, D2);
        add(4'b0000, 1, 0, 64'h0, 4'b0000, 4'b0000, 0, 32'h2000, 0, 2'd0, D2);

        tick();
        tick();
        check("reset_state", snap(), 108'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid    = tbl[i].rv;
            mem_ready    = tbl[i].mr;
            mem_complete = tbl[i].mc;
            mem_data     = tbl[i].md;
            tick();
            check($sformatf("vec%0d", i), snap(),
                  {tbl[i].e_rdy, tbl[i].e_cmp, tbl[i].e_mreq, tbl[i].e_addr,
                   tbl[i].e_busy, tbl[i].e_st, tbl[i].e_data});
        end
        req_valid    = '0;
        mem_complete = 1'b0;
        tick();

        // Reset while in WAIT, then a late completion pulse.
        req_valid = 4'b1000;
        mem_ready = 1'b1;
        tick();
        check("mid_issue", snap(), {4'b1000, 4'b0000, 1'b1, 32'h3000, 1'b1, 2'd1, D2});
        req_valid = '0;
        tick();
        check("mid_wait", snap(), {4'b0000, 4'b0000, 1'b0, 32'h3000, 1'b1, 2'd2, D2});
        #2 reset = 1'b1;
        #1 check("async_reset", snap(), 108'(0));
        mem_complete = 1'b1;
        mem_data     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        reset = 1'b0;
        tick();
        mem_complete = 1'b0;
        check("late_complete", snap(), 108'(0));
        tick();

`ifdef MEM_ARB_FIXED_PRI_EN
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
        do_grants(4'b1111, 5);

        exp_q = '{2'd3};
        do_grants(4'b1000, 1);
`ifdef MEM_ARB_FIXED_PRI_EN
        exp_q = '{2'd0, 2'd0};
`else
        exp_q = '{2'd0, 2'd3};
`endif
        do_grants(4'b1001, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
